// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the byte width and byte type that the TX and RX datapaths use,
// plus the default baud divisor constant.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;

  // Baud divisor used when nothing else is programmed.
  localparam logic [15:0] UART_BAUD_DIV_DEFAULT = 16'd867;

endpackage : uart_pkg

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word fall-through byte FIFO sitting in front of uart_tx.
// The RX side instantiates the same module with rx_byte_o -> wr_data_i and
// rx_o -> wr_en_i.
//
// Ports:
//   clock         system clock
//   resetn        synchronous active-low reset
//   wr_en_i       push request, one byte per cycle
//   wr_data_i     byte to push
//   flush_i       drop all contents and clear overflow
//   thresh_i      low-watermark level for irq_o
//   tx_dequeue_i  single-cycle pop pulse from uart_tx
//   tx_valid_o    head byte available (to uart_tx tx_i)
//   tx_byte_o     head byte (to uart_tx tx_byte_i)
//   full_o        level == DEPTH
//   empty_o       level == 0
//   level_o       occupancy, 0..DEPTH
//   overflow_o    sticky: a push was dropped because the FIFO was full
//   irq_o         registered, level_o <= thresh_i
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   wr_en_i,
  input  logic [UART_BYTE_W-1:0] wr_data_i,
  input  logic                   flush_i,
  input  logic [AW:0]            thresh_i,
  input  logic                   tx_dequeue_i,
  output logic                   tx_valid_o,
  output logic [UART_BYTE_W-1:0] tx_byte_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [AW:0]            level_o,
  output logic                   overflow_o,
  output logic                   irq_o
);

  // Storage is not reset; pointers alone define what is valid.
  uart_byte_t mem [DEPTH];

  // One extra wrap bit on each pointer lets level span 0..DEPTH without
  // a separate count register.
  logic [AW:0] wptr, rptr;
  logic [AW:0] level, next_level;
  logic        push, pop;

  assign level   = wptr - rptr;
  assign full_o  = (level == (AW+1)'(DEPTH));
  assign empty_o = (level == '0);
  assign level_o = level;

  assign tx_valid_o = !empty_o;
  assign tx_byte_o  = mem[rptr[AW-1:0]];

  // Full/empty are judged on the pre-edge state, so a push at full is
  // dropped even when a pop happens in the same cycle.
  assign push = wr_en_i && !full_o;
  assign pop  = tx_dequeue_i && !empty_o;

  always_comb begin
    next_level = level;
    if (flush_i)
      next_level = '0;
    else
      next_level = level + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wptr       <= '0;
      rptr       <= '0;
      overflow_o <= 1'b0;
      irq_o      <= 1'b0;
    end else begin
      irq_o <= (next_level <= thresh_i);
      if (flush_i) begin
        wptr       <= '0;
        rptr       <= '0;
        overflow_o <= 1'b0;
      end else begin
        if (push)
          wptr <= wptr + 1'b1;
        if (pop)
          rptr <= rptr + 1'b1;
        if (wr_en_i && full_o)
          overflow_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (resetn && !flush_i && push)
      mem[wptr[AW-1:0]] <= wr_data_i;
  end

endmodule : uart_tx_fifo

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte FIFO directly upstream of uart_tx; buffers bytes written by the host/bus side.
- Presents the head byte and a valid level to uart_tx through tx_i/tx_byte_i.
- Pops the head when uart_tx pulses tx_dequeue_o.
- Provides level, full/empty, sticky overflow, and a low-watermark interrupt, so a bus wrapper can refill the FIFO without polling every byte.

Parameters:
- DEPTH, 16, number of byte entries; power of two, at least 2.
- AW, $clog2(DEPTH), pointer width; localparam, not overridable.

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous active-low reset, sampled on rising edge of clock
- wr_en_i  in  1  push request, one byte per cycle
- wr_data_i  in  8  byte to push
- flush_i  in  1  discard all contents; clears overflow
- thresh_i  in  AW+1  low-watermark level for irq_o
- tx_dequeue_i  in  1  single-cycle pop pulse; connects to uart_tx tx_dequeue_o
- tx_valid_o  out  1  head byte available; connects to uart_tx tx_i
- tx_byte_o  out  8  head byte; connects to uart_tx tx_byte_i
- full_o  out  1  level == DEPTH
- empty_o  out  1  level == 0
- level_o  out  AW+1  current occupancy, 0..DEPTH
- overflow_o  out  1  sticky; a push was dropped because the FIFO was full
- irq_o  out  1  registered; level_o <= thresh_i

Behaviour:
- Storage: DEPTH x 8 array, no reset on the array. Write pointer and read pointer are AW+1 bits each (extra wrap bit).
- level = wptr - rptr, modulo 2^(AW+1).
- full_o, empty_o, level_o and tx_valid_o are combinational from registered pointers. tx_valid_o = !empty_o.
- tx_byte_o = mem[rptr[AW-1:0]]: asynchronous read. It is stable while tx_valid_o is high and no pop occurs. Its value is don't-care when empty.

Reset (resetn low at an edge):
- wptr = 0, rptr = 0, overflow_o = 0, irq_o = 0.
- Resulting outputs: empty_o = 1, full_o = 0, level_o = 0, tx_valid_o = 0.
- Reset mid-operation discards all contents and takes priority over every other input.

Per-cycle priority, evaluated at each rising edge:
1. resetn low: reset as above.
2. flush_i high: wptr = rptr = 0 and overflow_o = 0. A concurrent push or pop is ignored.
3. Otherwise push and pop are evaluated independently:
   - Push accepted iff wr_en_i && !full_o. It writes mem[wptr] and increments wptr.
   - wr_en_i && full_o drops the byte and sets overflow_o = 1. This holds even if a pop occurs in the same cycle: full is judged on the pre-edge state.
   - Pop accepted iff tx_dequeue_i && !empty_o. It increments rptr.
   - tx_dequeue_i while empty is ignored; pointers do not change.
   - Push and pop in the same cycle with 0 < level < DEPTH: both occur and level is unchanged.
   - Push while empty plus tx_dequeue_i: push only, because the pop is ignored; level becomes 1.

Timing and wrap:
- Latency: a byte pushed at edge N is visible with tx_valid_o = 1 after edge N (first-word fall-through, zero extra cycles).
- After a pop at edge N, the next byte appears on tx_byte_o after edge N.
- Pointer wrap is natural modulo 2^(AW+1); there is no special handling at DEPTH-1 -> 0.

irq_o:
- irq_o <= (next_level <= thresh_i), updated every non-reset cycle, including flush.
- thresh_i = 0 asserts irq_o only when the FIFO is empty.
- thresh_i >= DEPTH keeps irq_o asserted.

Decomposition:
- Shared package uart_pkg:
  - UART_BYTE_W = 8
  - typedef logic [7:0] uart_byte_t
  - default baud divisor constant, 16'd867
- No sub-module. Storage, pointers and flags fit in one module.
- The RX side reuses the same module by instantiation: rx_byte_o -> wr_data_i, rx_o -> wr_en_i.

Test Plan:
- Reset with no traffic: after reset, expect empty_o = 1, level_o = 0, tx_valid_o = 0, overflow_o = 0. With thresh_i = 0, expect irq_o = 1 after the first non-reset edge.
- Push 0x41, 0x42, 0x43 on consecutive cycles, then pulse tx_dequeue_i three times:
  - Expect tx_valid_o high one edge after the first push.
  - Expect tx_byte_o sequence 0x41, 0x42, 0x43; level_o 3 -> 2 -> 1 -> 0; empty_o = 1 at the end.
- Fill to DEPTH = 16 with 0x00..0x0F, then push 0xFF:
  - Expect full_o = 1 and overflow_o = 1 sticky; level_o stays 16.
  - Draining yields 0x00..0x0F; 0xFF never appears.
- Simultaneous push/pop at level 5, repeated for 40 cycles with an incrementing byte value:
  - Expect level_o constant 5 and output bytes in order across pointer wrap.
  - Repeat at level 16 with a push: the push is dropped, overflow_o sets, and level_o becomes 15.
- Flush at level 7 with a concurrent wr_en_i of 0x55 and tx_dequeue_i:
  - Expect level_o = 0, overflow_o cleared, and 0x55 not stored.
  - Then push 0x66: expect tx_byte_o = 0x66.
- Watermark and reset mid-stream, with thresh_i = 4:
  - Fill to 8: irq_o = 0. Drain to 4: irq_o = 1 one edge later.
  - Assert resetn low while level = 3: expect level_o = 0 and tx_valid_o = 0 after the edge.
  - Dequeue pulses while empty: pointers unchanged.
